// File: rtl/pred_disp_pkg.sv
// Shared types and constants for the prediction display.
// Holds the FSM state enum, the blank and dash segment patterns, and the
// active-low gfedcba encoding table for the digits 0..9.
package pred_disp_pkg;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StHighlight = 2'd1,
    StHold      = 2'd2
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Index is the digit value; bit order is {g,f,e,d,c,b,a}, active low.
  localparam logic [6:0] SEG_TABLE [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

endpackage

// File: rtl/seg7_digit.sv
// One active-low seven-segment digit decoder (combinational).
// Ports:
//   i_value : 4-bit value to show
//   i_valid : when low the digit is blank
//   o_seg   : active-low segments {g,f,e,d,c,b,a}; 10..15 show a dash
module seg7_digit
  import pred_disp_pkg::*;
(
  input  logic [3:0] i_value,
  input  logic       i_valid,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (i_valid) begin
      o_seg = (i_value < 4'd10) ? SEG_TABLE[i_value] : SEG_DASH;
    end
  end

endmodule

// File: rtl/prediction_display.sv
// Captures neural-network predictions on each rising edge of done, keeps the
// last four in a shift history shown on hex3..hex0 (hex0 newest), and blinks
// the newest digit for four half-periods after each capture.
// Ports:
//   CLOCK_50  : system clock          resetn    : async reset, active high
//   done      : forward-pass level from the divided clock domain
//   argmax    : predicted class, stable around the done rise
//   clear     : synchronous history clear, wins over a same-cycle capture
//   hex0..3   : active-low digits     count     : captures so far, wrapping
//   new_pulse : one-cycle capture strobe
//   state_dbg : FSM state (0 idle, 1 highlight, 2 hold)
module prediction_display
  import pred_disp_pkg::*;
#(
  parameter int unsigned BLINK_CYCLES = 12_500_000,
  parameter int unsigned HIST_DEPTH   = 4
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       done,
  input  logic [3:0] argmax,
  input  logic       clear,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic [7:0] count,
  output logic       new_pulse,
  output logic [1:0] state_dbg
);

  localparam int unsigned CntW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  // Synchronizer, edge detect and arming
  logic            r_s1, r_s2, r_s3, r_armed;
  logic [1:0]      r_live;
  logic            w_capture;

  // History and FSM state
  logic [3:0]            r_val [HIST_DEPTH];
  logic [HIST_DEPTH-1:0] r_valid;
  logic [7:0]            r_count;
  logic                  r_new;
  state_e                r_state;
  logic [CntW-1:0]       r_cnt;
  logic                  r_phase;
  logic [1:0]            r_tog;

  logic [3:0]            w_val_nxt [HIST_DEPTH];
  logic [HIST_DEPTH-1:0] w_valid_nxt;
  logic [7:0]            w_count_nxt;
  logic                  w_new_nxt;
  state_e                w_state_nxt;
  logic [CntW-1:0]       w_cnt_nxt;
  logic                  w_phase_nxt;
  logic [1:0]            w_tog_nxt;

  // r_live marks when r_s2 holds a real sample of done rather than its reset
  // value; capture is only armed after a genuine low has been seen, so a done
  // level already high at reset release never produces a capture.
  always_ff @(posedge CLOCK_50 or posedge resetn) begin
    if (resetn) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_s3    <= 1'b0;
      r_live  <= 2'b00;
      r_armed <= 1'b0;
    end else begin
      r_s1    <= done;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_live  <= {r_live[0], 1'b1};
      r_armed <= r_armed | (r_live[1] & ~r_s2);
    end
  end

  assign w_capture = r_s2 & ~r_s3 & r_armed;

  always_comb begin
    w_val_nxt   = r_val;
    w_valid_nxt = r_valid;
    w_count_nxt = r_count;
    w_new_nxt   = 1'b0;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_phase_nxt = r_phase;
    w_tog_nxt   = r_tog;
    if (clear) begin
      w_valid_nxt = '0;
      w_count_nxt = 8'd0;
      w_state_nxt = StIdle;
      w_cnt_nxt   = '0;
      w_phase_nxt = 1'b0;
      w_tog_nxt   = 2'd0;
    end else if (w_capture) begin
      for (int i = HIST_DEPTH - 1; i > 0; i--) begin
        w_val_nxt[i] = r_val[i-1];
      end
      w_val_nxt[0] = argmax;
      w_valid_nxt  = {r_valid[HIST_DEPTH-2:0], 1'b1};
      w_count_nxt  = r_count + 8'd1;
      w_new_nxt    = 1'b1;
      w_state_nxt  = StHighlight;
      w_cnt_nxt    = '0;
      w_phase_nxt  = 1'b0;
      w_tog_nxt    = 2'd0;
    end else begin
      unique case (r_state)
        StHighlight: begin
          if (r_cnt == CntW'(BLINK_CYCLES - 1)) begin
            w_cnt_nxt   = '0;
            w_phase_nxt = ~r_phase;
            if (r_tog == 2'd3) begin
              w_state_nxt = StHold;
              w_phase_nxt = 1'b0;
              w_tog_nxt   = 2'd0;
            end else begin
              w_tog_nxt = r_tog + 2'd1;
            end
          end else begin
            w_cnt_nxt = r_cnt + CntW'(1);
          end
        end
        StHold: begin
          if (!r_s2) w_state_nxt = StIdle;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge resetn) begin
    if (resetn) begin
      r_val   <= '{default: '0};
      r_valid <= '0;
      r_count <= 8'd0;
      r_new   <= 1'b0;
      r_state <= StIdle;
      r_cnt   <= '0;
      r_phase <= 1'b0;
      r_tog   <= 2'd0;
    end else begin
      r_val   <= w_val_nxt;
      r_valid <= w_valid_nxt;
      r_count <= w_count_nxt;
      r_new   <= w_new_nxt;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_phase <= w_phase_nxt;
      r_tog   <= w_tog_nxt;
    end
  end

  // Blink blanks only the newest digit, on the odd half-periods.
  logic                  w_blink;
  logic [HIST_DEPTH-1:0] w_dvalid;
  logic [6:0]            w_hex [4];

  assign w_blink  = (r_state == StHighlight) && r_phase;
  assign w_dvalid = r_valid & ~{{(HIST_DEPTH - 1){1'b0}}, w_blink};

  for (genvar g = 0; g < 4; g++) begin : g_digit
    seg7_digit u_digit (
      .i_value (r_val[g]),
      .i_valid (w_dvalid[g]),
      .o_seg   (w_hex[g])
    );
  end

  assign hex0      = w_hex[0];
  assign hex1      = w_hex[1];
  assign hex2      = w_hex[2];
  assign hex3      = w_hex[3];
  assign count     = r_count;
  assign new_pulse = r_new;
  assign state_dbg = r_state;

endmodule

// File: doc/prediction_display.md
PREDICTION_DISPLAY -- requirements
Module: prediction_display

Interface
REQ-001 SHALL have parameter BLINK_CYCLES, default 12_500_000, meaning CLOCK_50 cycles per blink half-period.
REQ-002 SHALL have parameter HIST_DEPTH, default 4, meaning number of retained predictions; it is fixed at 4.
REQ-003 SHALL have port CLOCK_50  input  1  system clock.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port done  input  1  forward-pass-complete level from the neural network, which runs in the divided clock domain.
REQ-006 SHALL have port argmax  input  4  predicted class, valid while done is high.
REQ-007 SHALL have port clear  input  1  synchronous history-clear request in the CLOCK_50 domain.
REQ-008 SHALL have ports hex0..hex3  output  7 each  active-low seven-segment digits; hex0 holds the newest prediction.
REQ-009 SHALL have port count  output  8  number of captured predictions, wrapping.
REQ-010 SHALL have port new_pulse  output  1  one-cycle strobe on each capture.
REQ-011 SHALL have port state_dbg  output  2  current FSM state, for LED debug.

Function
REQ-012 SHALL pass done through a 2-flop synchronizer, then rising-edge detect it against a third flop.
REQ-013 SHALL require argmax to be stable from at least 3 CLOCK_50 cycles before done rises until done falls.
REQ-014 SHALL capture argmax and assert new_pulse exactly 3 CLOCK_50 cycles after done rises at the pin; no capture occurs while done stays high.
REQ-015 SHALL shift history on capture: slot3<=slot2, slot2<=slot1, slot1<=slot0, slot0<=argmax; each slot carries a valid bit.
REQ-016 SHALL drive invalid slots as blank (1111111).
REQ-017 SHALL drive valid slots holding 0..9 with the standard active-low encoding (0=1000000 ... 9=0010000).
REQ-018 SHALL drive valid slots holding 10..15 as dash (0111111).
REQ-019 SHALL increment count on capture, wrapping 255->0.
REQ-020 SHALL implement FSM states IDLE, HIGHLIGHT, HOLD.
REQ-021 IDLE: on capture, go to HIGHLIGHT, load the blink counter to 0, set phase=0.
REQ-022 HIGHLIGHT: the blink counter counts 0..BLINK_CYCLES-1; at terminal count, phase toggles.
REQ-023 HIGHLIGHT: hex0 is forced blank while phase=1.
REQ-024 HIGHLIGHT: after 4 toggles, go to HOLD with phase=0.
REQ-025 HOLD: all digits static; go to IDLE when synchronized done is low.
REQ-026 HOLD: a capture in HOLD (done re-rise) goes to HIGHLIGHT.
REQ-027 SHALL, on a capture during HIGHLIGHT, shift normally and restart HIGHLIGHT with counter=0, phase=0, toggles=0.
REQ-028 SHALL give clear priority over a same-cycle capture: invalidate all slots, count<=0, new_pulse=0, state<=IDLE, phase<=0.
REQ-029 SHALL drive state_dbg as IDLE=0, HIGHLIGHT=1, HOLD=2.

Reset
REQ-030 SHALL, while resetn is high, asynchronously force: synchronizer flops 0, all slots invalid, hex0..hex3=1111111, count=0, new_pulse=0, state=IDLE (state_dbg=0), counters 0, phase 0.
REQ-031 SHALL, after resetn deasserts with done already high, perform no capture until done falls and rises again; edge-detect flops reset to 0 and sync must see a low first.
REQ-032 SHALL, on reset mid-HIGHLIGHT, abandon the blink and blank all digits immediately.

Structure
REQ-033 SHALL place in shared package pred_disp_pkg: the state enum, SEG_BLANK=1111111, SEG_DASH=0111111, and the 10-entry digit encoding table.
REQ-034 SHALL use one sub-module, seg7_digit (4-bit value + valid -> 7-bit active-low), instantiated four times; it is combinational and uses the package table.
REQ-035 SHALL keep all registers in the CLOCK_50 domain; the synchronizer is the only crossing.

Verification (bench uses BLINK_CYCLES=4)
REQ-036 Reset then idle: all hex=1111111, count=0, state_dbg=0.
REQ-037 Raise done with argmax=7 -> new_pulse high on the 3rd cycle after the rise; hex0=1111000; hex1..3 blank; count=1; hex0 blanks for cycles 4-7 and 12-15 of HIGHLIGHT; state_dbg=2 after 16 cycles.
REQ-038 Four passes with argmax 3,1,4,12 -> hex3..hex0 = 0110000, 1111001, 0011001, 0111111; count=4.
REQ-039 Hold done high for 100 cycles -> exactly one new_pulse.
REQ-040 Second done edge 6 cycles into HIGHLIGHT with argmax=2 -> hex0=0100100, hex1=previous value, blink restarts with phase=0.
REQ-041 Assert clear in the same cycle as a capture edge -> no new_pulse, all blank, count=0, state_dbg=0.
REQ-042 Capture 256 times -> count wraps to 0.
REQ-043 Pulse resetn mid-HIGHLIGHT -> immediate blank outputs.
